// File: rtl/trap_seq_ctrl_pkg.sv
// ============================================================================
// Module      : trap_seq_ctrl_pkg
// Description : Shared cause codes, state encoding and helpers for the
//               machine-mode trap/return sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_seq_ctrl_pkg;

    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_NONE    = 4'd0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_TRAP_WR = 2'd1;
    localparam state_t ST_RET_WR  = 2'd2;
    localparam state_t ST_REDIR   = 2'd3;

    // mcause keeps its interrupt flag in the most significant bit.
    function automatic int irq_bit_pos(input int xlen);
        return xlen - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_seq_ctrl_prio_enc.sv
// ============================================================================
// Module      : trap_prio_enc
// Description : Combinational priority encoder: irq > ebreak > ecall > mret.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_prio_enc
    import trap_seq_ctrl_pkg::*;
(
    input  logic       irq_pend,
    input  logic       ebreak,
    input  logic       ecall,
    input  logic       mret,
    output logic       take_trap,
    output logic       take_ret,
    output logic       is_irq,
    output logic [3:0] cause
);

    always_comb begin
        take_trap = 1'b0;
        take_ret  = 1'b0;
        is_irq    = 1'b0;
        cause     = CAUSE_NONE;
        if (irq_pend) begin
            take_trap = 1'b1;
            is_irq    = 1'b1;
            cause     = CAUSE_MTI;
        end else if (ebreak) begin
            take_trap = 1'b1;
            cause     = CAUSE_EBREAK;
        end else if (ecall) begin
            take_trap = 1'b1;
            cause     = CAUSE_ECALL_M;
        end else if (mret) begin
            take_ret  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trap_seq_ctrl.sv
// ============================================================================
// Module      : trap_seq_ctrl
// Description : Machine-mode trap/return sequencer between commit and CSRs.
//               Optional macro TRAP_VECTORED_EN enables vectored interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_seq_ctrl
    import trap_seq_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int MTIP_FILTER = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_ecall,
    input  logic            commit_ebreak,
    input  logic            commit_mret,
    output logic            commit_ready,
    output logic            commit_kill,
    input  logic            clint_mtip,
    input  logic            mstatus_mie,
    input  logic            mie_mtie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            csr_trap_we,
    output logic [XLEN-1:0] csr_mepc_wdata,
    output logic [XLEN-1:0] csr_mcause_wdata,
    output logic            csr_mret_we,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    localparam int              IRQ_BIT    = irq_bit_pos(XLEN);
    localparam logic [3:0]      FILTER_MAX = 4'(MTIP_FILTER);
    localparam logic [XLEN-1:0] BASE_MASK  = ~{{(XLEN-2){1'b0}}, 2'b11};

    state_t          state_q, state_d;
    logic [3:0]      filt_q, filt_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [3:0]      cause_q, cause_d;
    logic            irq_q, irq_d;

    logic            idle_commit;
    logic            irq_pend;
    logic            take_trap, take_ret, enc_irq;
    logic [3:0]      enc_cause;
    logic [XLEN-1:0] tgt_base, tgt_trap;
    logic [XLEN-1:0] mcause_word;

    // Timer level must persist for MTIP_FILTER samples before it is honoured.
    always_comb begin
        filt_d = '0;
        if (clint_mtip) begin
            filt_d = (filt_q == FILTER_MAX) ? filt_q : filt_q + 4'd1;
        end
    end

    assign irq_pend    = (filt_q == FILTER_MAX) & mstatus_mie & mie_mtie;
    assign idle_commit = (state_q == ST_IDLE) & commit_valid;

    trap_prio_enc u_prio_enc (
        .irq_pend  (idle_commit & irq_pend),
        .ebreak    (idle_commit & commit_ebreak),
        .ecall     (idle_commit & commit_ecall),
        .mret      (idle_commit & commit_mret),
        .take_trap (take_trap),
        .take_ret  (take_ret),
        .is_irq    (enc_irq),
        .cause     (enc_cause)
    );

    assign tgt_base = mtvec & BASE_MASK;

`ifdef TRAP_VECTORED_EN
    assign tgt_trap = ((mtvec[1:0] == 2'b01) && irq_q)
                    ? tgt_base + {{(XLEN-6){1'b0}}, cause_q, 2'b00}
                    : tgt_base;
`else
    assign tgt_trap = tgt_base;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            filt_q  <= '0;
            epc_q   <= '0;
            tgt_q   <= '0;
            cause_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            epc_q   <= epc_d;
            tgt_q   <= tgt_d;
            cause_q <= cause_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        tgt_d   = tgt_q;
        cause_d = cause_q;
        irq_d   = irq_q;
        case (state_q)
            ST_IDLE: begin
                if (take_trap) begin
                    state_d = ST_TRAP_WR;
                    epc_d   = commit_pc;
                    cause_d = enc_cause;
                    irq_d   = enc_irq;
                end else if (take_ret) begin
                    state_d = ST_RET_WR;
                end
            end
            ST_TRAP_WR: begin
                tgt_d   = tgt_trap;
                state_d = ST_REDIR;
            end
            ST_RET_WR: begin
                tgt_d   = mepc;
                state_d = ST_REDIR;
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mcause_word          = '0;
        mcause_word[3:0]     = cause_q;
        mcause_word[IRQ_BIT] = irq_q;
    end

    always_comb begin
        commit_ready     = 1'b0;
        commit_kill      = 1'b0;
        csr_trap_we      = 1'b0;
        csr_mepc_wdata   = '0;
        csr_mcause_wdata = '0;
        csr_mret_we      = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        busy             = 1'b1;
        case (state_q)
            ST_IDLE: begin
                commit_ready = 1'b1;
                busy         = 1'b0;
                commit_kill  = take_trap & enc_irq;
            end
            ST_TRAP_WR: begin
                csr_trap_we      = 1'b1;
                csr_mepc_wdata   = epc_q;
                csr_mcause_wdata = mcause_word;
            end
            ST_RET_WR: begin
                csr_mret_we = 1'b1;
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
            end
            default: busy = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_seq_ctrl.sv
// ============================================================================
// Module      : tb_trap_seq_ctrl
// Description : Directed self-checking bench for trap_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_seq_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            commit_valid, commit_ecall, commit_ebreak, commit_mret;
    logic [XLEN-1:0] commit_pc;
    logic            commit_ready, commit_kill;
    logic            clint_mtip, mstatus_mie, mie_mtie;
    logic [XLEN-1:0] mtvec, mepc;
    logic            csr_trap_we, csr_mret_we;
    logic [XLEN-1:0] csr_mepc_wdata, csr_mcause_wdata;
    logic            redirect_valid, redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    int checks = 0;
    int errors = 0;

    trap_seq_ctrl #(.XLEN(XLEN), .MTIP_FILTER(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_ecall     (commit_ecall),
        .commit_ebreak    (commit_ebreak),
        .commit_mret      (commit_mret),
        .commit_ready     (commit_ready),
        .commit_kill      (commit_kill),
        .clint_mtip       (clint_mtip),
        .mstatus_mie      (mstatus_mie),
        .mie_mtie         (mie_mtie),
        .mtvec            (mtvec),
        .mepc             (mepc),
        .csr_trap_we      (csr_trap_we),
        .csr_mepc_wdata   (csr_mepc_wdata),
        .csr_mcause_wdata (csr_mcause_wdata),
        .csr_mret_we      (csr_mret_we),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        commit_valid  = 1'b0;
        commit_ecall  = 1'b0;
        commit_ebreak = 1'b0;
        commit_mret   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_commit();
        commit_pc = '0; clint_mtip = 1'b0; mstatus_mie = 1'b1; mie_mtie = 1'b1;
        mtvec = '0; mepc = '0; redirect_ready = 1'b0;
        tick(); tick();
        checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", commit_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if ({csr_trap_we, csr_mret_we, redirect_valid, commit_kill} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b exp 0000", {csr_trap_we, csr_mret_we, redirect_valid, commit_kill}); end
        checks++; if ({csr_mepc_wdata, csr_mcause_wdata, redirect_pc} !== '0) begin
            errors++; $display("FAIL reset_data: mepc %h mcause %h pc %h exp 0", csr_mepc_wdata, csr_mcause_wdata, redirect_pc); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ecall();
        commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h8000_0100;
        mtvec = 64'h8000_0520; redirect_ready = 1'b1;
        #1;
        checks++; if (commit_kill !== 1'b0) begin errors++; $display("FAIL ecall_kill: got %b exp 0", commit_kill); end
        tick(); clear_commit();
        checks++; if (csr_trap_we !== 1'b1) begin errors++; $display("FAIL ecall_trap_we: got %b exp 1", csr_trap_we); end
        checks++; if (csr_mepc_wdata !== 64'h8000_0100) begin errors++; $display("FAIL ecall_mepc: got %h exp 80000100", csr_mepc_wdata); end
        checks++; if (csr_mcause_wdata !== 64'd11) begin errors++; $display("FAIL ecall_mcause: got %h exp b", csr_mcause_wdata); end
        checks++; if (commit_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ecall_busy: ready %b busy %b exp 0 1", commit_ready, busy); end
        tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0520) begin
            errors++; $display("FAIL ecall_redirect: valid %b pc %h exp 1 80000520", redirect_valid, redirect_pc); end
        checks++; if (csr_trap_we !== 1'b0 || csr_mepc_wdata !== '0) begin
            errors++; $display("FAIL ecall_strobe_once: we %b mepc %h exp 0 0", csr_trap_we, csr_mepc_wdata); end
        tick();
        checks++; if (commit_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL ecall_return: ready %b valid %b exp 1 0", commit_ready, redirect_valid); end
    endtask

    task automatic test_mret_stall();
        int pulses;
        pulses = 0;
        commit_valid = 1'b1; commit_mret = 1'b1; mepc = 64'h8000_0104; redirect_ready = 1'b0;
        tick(); clear_commit();
        checks++; if (csr_mret_we !== 1'b1 || csr_trap_we !== 1'b0) begin
            errors++; $display("FAIL mret_we: mret %b trap %b exp 1 0", csr_mret_we, csr_trap_we); end
        tick();
        mepc = 64'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) redirect_ready = 1'b1;
            #1;
            if (csr_mret_we) pulses++;
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0104) begin
                errors++; $display("FAIL mret_hold_%0d: valid %b pc %h exp 1 80000104", i, redirect_valid, redirect_pc); end
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mret_single_pulse: extra pulses %0d exp 0", pulses); end
        checks++; if (redirect_valid !== 1'b0 || commit_ready !== 1'b1) begin
            errors++; $display("FAIL mret_return: valid %b ready %b exp 0 1", redirect_valid, commit_ready); end
    endtask

    task automatic test_irq();
        logic [XLEN-1:0] exp_pc;
`ifdef TRAP_VECTORED_EN
        exp_pc = 64'h101C;
`else
        exp_pc = 64'h1000;
`endif
        mstatus_mie = 1'b1; mie_mtie = 1'b1; mtvec = 64'h1001; redirect_ready = 1'b1;
        clint_mtip = 1'b1; commit_valid = 1'b1; commit_pc = 64'h1F0;
        #1;
        checks++; if (commit_kill !== 1'b0) begin errors++; $display("FAIL irq_filter0: kill %b exp 0", commit_kill); end
        tick();
        checks++; if (commit_kill !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL irq_filter1: kill %b busy %b exp 0 0", commit_kill, busy); end
        tick();
        commit_ecall = 1'b1; commit_pc = 64'h200;
        #1;
        checks++; if (commit_kill !== 1'b1) begin errors++; $display("FAIL irq_kill: got %b exp 1", commit_kill); end
        tick(); clear_commit();
        checks++; if (csr_mcause_wdata !== 64'h8000_0000_0000_0007) begin
            errors++; $display("FAIL irq_mcause: got %h exp 8000000000000007", csr_mcause_wdata); end
        checks++; if (csr_mepc_wdata !== 64'h200) begin errors++; $display("FAIL irq_mepc: got %h exp 200", csr_mepc_wdata); end
        tick();
        checks++; if (redirect_pc !== exp_pc) begin errors++; $display("FAIL irq_target: got %h exp %h", redirect_pc, exp_pc); end
        tick();
    endtask

    task automatic test_irq_masked();
        mstatus_mie = 1'b0;
        commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h300;
        #1;
        checks++; if (commit_kill !== 1'b0) begin errors++; $display("FAIL masked_kill: got %b exp 0", commit_kill); end
        tick(); clear_commit();
        checks++; if (csr_mcause_wdata !== 64'd11 || csr_mepc_wdata !== 64'h300) begin
            errors++; $display("FAIL masked_cause: mcause %h mepc %h exp b 300", csr_mcause_wdata, csr_mepc_wdata); end
        tick();
        checks++; if (redirect_pc !== 64'h1000) begin errors++; $display("FAIL masked_target: got %h exp 1000", redirect_pc); end
        tick();
        clint_mtip = 1'b0; mstatus_mie = 1'b1;
    endtask

    task automatic test_reset_in_redir();
        commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h400;
        mtvec = 64'h8000_0520; redirect_ready = 1'b0;
        tick(); clear_commit();
        tick();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_redir: valid %b exp 1", redirect_valid); end
        rst = 1'b0;
        tick();
        checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0 || commit_ready !== 1'b1) begin
            errors++; $display("FAIL rst_abort: valid %b busy %b ready %b exp 0 0 1", redirect_valid, busy, commit_ready); end
        rst = 1'b1; redirect_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({csr_trap_we, csr_mret_we, redirect_valid} !== 3'b000) begin
                errors++; $display("FAIL rst_quiet_%0d: got %b exp 000", i, {csr_trap_we, csr_mret_we, redirect_valid}); end
        end
    endtask

    task automatic test_priority();
        commit_valid = 1'b1; commit_ecall = 1'b1; commit_ebreak = 1'b1; commit_mret = 1'b1;
        commit_pc = 64'h500; redirect_ready = 1'b1;
        tick(); clear_commit();
        checks++; if (csr_mcause_wdata !== 64'd3 || csr_mret_we !== 1'b0) begin
            errors++; $display("FAIL prio_ebreak: mcause %h mret_we %b exp 3 0", csr_mcause_wdata, csr_mret_we); end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        commit_valid = 1'b1; commit_mret = 1'b1; mepc = 64'h700;
        #1;
        checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", commit_ready); end
        tick();
        // commit_valid still high here: non-IDLE states must ignore it
        checks++; if (csr_mret_we !== 1'b1 || commit_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_mret: we %b ready %b exp 1 0", csr_mret_we, commit_ready); end
        tick(); clear_commit();
        checks++; if (redirect_pc !== 64'h700 || csr_mret_we !== 1'b0) begin
            errors++; $display("FAIL b2b_redirect: pc %h we %b exp 700 0", redirect_pc, csr_mret_we); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret_stall();
        test_irq();
        test_irq_masked();
        test_reset_in_redir();
        test_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
